// File: rtl/lab1_imul_int_mul_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) behind val/rdy request/response ports.
// Optional variable-latency early exit: define LAB1_IMUL_EARLY_EXIT_EN.
module lab1_imul_int_mul_iter #(
   parameter int unsigned p_nbits = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_val,
   output logic                   req_rdy,
   input  logic [2*p_nbits+1:0]   req_msg,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic [p_nbits-1:0]     resp_msg
);

   localparam int unsigned N  = p_nbits;
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULH   = 2'd1,
      OP_MULHSU = 2'd2,
      OP_MULHU  = 2'd3
   } op_t;

   state_t           state;
   state_t           state_next;

   logic [1:0]       op_r;
   logic [2*N-1:0]   a_sh;
   logic [N-1:0]     b_r;
   logic [2*N-1:0]   acc;
   logic [CW-1:0]    count;
   logic             neg;

   // Request decode
   logic [1:0]       in_op;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic             in_a_neg;
   logic             in_b_neg;
   logic [N-1:0]     in_a_mag;
   logic [N-1:0]     in_b_mag;

   always_comb begin
      in_op    = req_msg[2*N+1:2*N];
      in_a     = req_msg[2*N-1:N];
      in_b     = req_msg[N-1:0];
      in_a_neg = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[N-1];
      in_b_neg = (in_op == OP_MULH) && in_b[N-1];
      in_a_mag = in_a_neg ? -in_a : in_a;
      in_b_mag = in_b_neg ? -in_b : in_b;
   end

   logic             accept;
   logic             calc_last;
   logic [2*N-1:0]   acc_step;

   always_comb begin
      accept   = req_val && req_rdy;
      acc_step = b_r[0] ? (acc + a_sh) : acc;
`ifdef LAB1_IMUL_EARLY_EXIT_EN
      // Nothing left to add once every bit above the one consumed this cycle is zero.
      calc_last = (count == CW'(N - 1)) || (b_r[N-1:1] == '0);
`else
      calc_last = (count == CW'(N - 1));
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_val)   state_next = CALC;
         CALC:    if (calc_last) state_next = DONE;
         DONE:    if (resp_rdy)  state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r  <= '0;
         a_sh  <= '0;
         b_r   <= '0;
         acc   <= '0;
         count <= '0;
         neg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_r  <= in_op;
                  a_sh  <= {{N{1'b0}}, in_a_mag};
                  b_r   <= in_b_mag;
                  acc   <= '0;
                  count <= '0;
                  neg   <= in_a_neg ^ in_b_neg;
               end
            end
            CALC: begin
               acc   <= acc_step;
               a_sh  <= a_sh << 1;
               b_r   <= b_r >> 1;
               count <= count + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   logic [2*N-1:0]   prod;

   // Output logic; everything forced low while reset is asserted
   always_comb begin
      prod     = neg ? -acc : acc;
      req_rdy  = !reset && (state == IDLE);
      resp_val = !reset && (state == DONE);
      resp_msg = '0;
      if (!reset) begin
         resp_msg = (op_r == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
      end
   end

endmodule
